// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7O1 serial receiver: state codes, frame geometry, default baud.
package rx_serial_pkg;

  localparam int FRAME_BITS           = 8;   // d0..d6 plus parity
  localparam int DATA_BITS            = 7;
  localparam int DEFAULT_CLKS_PER_BIT = 434; // 50 MHz / 115200 baud

  localparam logic [3:0] ST_INICIAL  = 4'd0;
  localparam logic [3:0] ST_PREPARA  = 4'd1;
  localparam logic [3:0] ST_ESPERA   = 4'd2;
  localparam logic [3:0] ST_RECEBE   = 4'd3;
  localparam logic [3:0] ST_STOP     = 4'd4;
  localparam logic [3:0] ST_ARMAZENA = 4'd5;
  localparam logic [3:0] ST_FINAL    = 4'd6;

  typedef enum logic [3:0] {
    INICIAL  = ST_INICIAL,
    PREPARA  = ST_PREPARA,
    ESPERA   = ST_ESPERA,
    RECEBE   = ST_RECEBE,
    STOP     = ST_STOP,
    ARMAZENA = ST_ARMAZENA,
    FINAL    = ST_FINAL
  } state_t;

endpackage

// File: rtl/rx_serial_7o1_fd.sv
// Datapath of the 7O1 receiver: baud counter with half/full-bit ticks, bit index,
// shift register and the registered character, flags and data-available level.
module rx_serial_7o1_fd
  import rx_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 line,
  input  logic                 cnt_clr,
  input  logic                 cnt_en,
  input  logic                 sr_clr,
  input  logic                 bit_clr,
  input  logic                 shift_en,
  input  logic                 stop_en,
  input  logic                 load,
  input  logic                 recebe_dado,
  output logic                 meio,
  output logic                 fim,
  output logic                 bit_last,
  output logic [DATA_BITS-1:0] dado_recebido,
  output logic                 paridade_ok,
  output logic                 erro_quadro,
  output logic                 tem_dado
);

  localparam int              BIT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] MEIO_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FIM_CNT  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_idx;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  stop_bit;

  assign meio     = (cnt == MEIO_CNT);
  assign fim      = (cnt == FIM_CNT);
  assign bit_last = (bit_idx == BIT_W'(FRAME_BITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset || cnt_clr) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= fim ? '0 : cnt + 1'b1;
    end
  end

  // Bits arrive LSB first, so shifting in at the top leaves d0 in bit 0 and parity in bit 7.
  always_ff @(posedge clock) begin
    if (!reset || sr_clr) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      stop_bit  <= 1'b0;
    end else begin
      if (bit_clr) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (shift_en) begin
        shift_reg <= {line, shift_reg[FRAME_BITS-1:1]};
      end
      if (stop_en) begin
        stop_bit <= line;
      end
    end
  end

  // Frames with bad parity or framing are still stored; the flags let the consumer decide.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dado_recebido <= '0;
      paridade_ok   <= 1'b0;
      erro_quadro   <= 1'b0;
    end else if (load) begin
      dado_recebido <= shift_reg[DATA_BITS-1:0];
      paridade_ok   <= ^shift_reg;
      erro_quadro   <= ~stop_bit;
    end
  end

  // A new character outranks a simultaneous acknowledge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tem_dado <= 1'b0;
    end else if (load) begin
      tem_dado <= 1'b1;
    end else if (recebe_dado) begin
      tem_dado <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver (start, 7 data LSB first, odd parity, stop), mid-bit sampling.
// Define RX_SYNC_EN to pass dado_serial through a 2-flop synchronizer before the FSM.
module rx_serial_7o1
  import rx_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
  input  logic                 recebe_dado,
  output logic [DATA_BITS-1:0] dado_recebido,
  output logic                 paridade_ok,
  output logic                 erro_quadro,
  output logic                 tem_dado,
  output logic                 pronto,
  output logic [3:0]           db_estado
);

  state_t state, state_next;
  logic   line;
  logic   cnt_clr, cnt_en, sr_clr, bit_clr, shift_en, stop_en, load;
  logic   meio, fim, bit_last;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  // Reset to idle-high so leaving reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], dado_serial};
    end
  end

  assign line = sync_q[1];
`else
  assign line = dado_serial;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= INICIAL;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    sr_clr     = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    stop_en    = 1'b0;
    load       = 1'b0;
    pronto     = 1'b0;
    unique case (state)
      INICIAL: begin
        cnt_clr    = 1'b1;
        sr_clr     = 1'b1;
        state_next = PREPARA;
      end
      PREPARA: begin
        cnt_clr = 1'b1;
        if (!line) state_next = ESPERA;
      end
      ESPERA: begin
        cnt_en = 1'b1;
        if (meio) begin
          cnt_clr    = 1'b1;
          bit_clr    = 1'b1;
          state_next = line ? PREPARA : RECEBE;
        end
      end
      RECEBE: begin
        cnt_en = 1'b1;
        if (fim) begin
          shift_en = 1'b1;
          if (bit_last) state_next = STOP;
        end
      end
      STOP: begin
        cnt_en = 1'b1;
        if (fim) begin
          stop_en    = 1'b1;
          state_next = ARMAZENA;
        end
      end
      ARMAZENA: begin
        load       = 1'b1;
        state_next = FINAL;
      end
      FINAL: begin
        pronto     = 1'b1;
        state_next = PREPARA;
      end
      default: state_next = INICIAL;
    endcase
  end

  assign db_estado = state;

  rx_serial_7o1_fd #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_fd (
    .clock        (clock),
    .reset        (reset),
    .line         (line),
    .cnt_clr      (cnt_clr),
    .cnt_en       (cnt_en),
    .sr_clr       (sr_clr),
    .bit_clr      (bit_clr),
    .shift_en     (shift_en),
    .stop_en      (stop_en),
    .load         (load),
    .recebe_dado  (recebe_dado),
    .meio         (meio),
    .fim          (fim),
    .bit_last     (bit_last),
    .dado_recebido(dado_recebido),
    .paridade_ok  (paridade_ok),
    .erro_quadro  (erro_quadro),
    .tem_dado     (tem_dado)
  );

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Scoreboard bench for rx_serial_7o1: frames are queued with their expected contents and
// pronto cycle when driven, and checked when pronto appears.
module tb_rx_serial_7o1;

  localparam int CLKS = 434;
  // First edge seeing the start bit -> edge that raises pronto: half bit, 9 full bits, 1 store cycle.
`ifdef RX_SYNC_EN
  localparam int LAT = 1 + CLKS / 2 + 9 * CLKS + 1 + 2;
`else
  localparam int LAT = 1 + CLKS / 2 + 9 * CLKS + 1;
`endif

  typedef struct {
    logic [6:0] data;
    logic       par_ok;
    logic       frm_err;
    int         cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       dado_serial;
  logic       recebe_dado;
  logic [6:0] dado_recebido;
  logic       paridade_ok;
  logic       erro_quadro;
  logic       tem_dado;
  logic       pronto;
  logic [3:0] db_estado;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;

  rx_serial_7o1 #(.CLKS_PER_BIT(CLKS), .CNT_W(9)) dut (
    .clock        (clock),
    .reset        (reset),
    .dado_serial  (dado_serial),
    .recebe_dado  (recebe_dado),
    .dado_recebido(dado_recebido),
    .paridade_ok  (paridade_ok),
    .erro_quadro  (erro_quadro),
    .tem_dado     (tem_dado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives start, 7 data bits, parity p, stop s for ncyc cycles; must be called at a negedge.
  task automatic drive_frame(input logic [6:0] d, input logic p, input logic s,
                             input int ncyc, input bit push);
    logic [9:0] bits;
    exp_t       e;
    bits = {s, p, d, 1'b0};
    if (push) begin
      e.data    = d;
      e.par_ok  = ^{d, p};
      e.frm_err = ~s;
      e.cyc     = cyc + LAT;
      sb.push_back(e);
    end
    for (int i = 0; i < ncyc; i++) begin
      dado_serial = bits[i / CLKS];
      @(negedge clock);
    end
    dado_serial = 1'b1;
  endtask

  task automatic full_frame(input logic [6:0] d, input logic p, input logic s);
    drive_frame(d, p, s, 10 * CLKS, 1'b1);
  endtask

  function automatic logic odd_par(input logic [6:0] d);
    return ~^d;
  endfunction

  always @(negedge clock) begin
    if (pronto) begin
      check("pronto_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("dado_recebido", 32'(dado_recebido), 32'(mon_e.data));
        check("paridade_ok",   32'(paridade_ok),   32'(mon_e.par_ok));
        check("erro_quadro",   32'(erro_quadro),   32'(mon_e.frm_err));
        check("tem_dado_set",  32'(tem_dado),      32'd1);
        check("pronto_cycle",  32'(cyc),           32'(mon_e.cyc));
      end
    end
  end

  initial begin
    reset       = 1'b0;
    dado_serial = 1'b1;
    recebe_dado = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_estado", 32'(db_estado),     32'd0);
    check("rst_dado",   32'(dado_recebido), 32'd0);
    check("rst_par",    32'(paridade_ok),   32'd0);
    check("rst_err",    32'(erro_quadro),   32'd0);
    check("rst_tem",    32'(tem_dado),      32'd0);
    check("rst_pronto", 32'(pronto),        32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("after_rst_prepara", 32'(db_estado), 32'd1);
    repeat (5) @(negedge clock);

    // 'A' with correct parity, then acknowledge.
    full_frame(7'h41, odd_par(7'h41), 1'b1);
    repeat (10) @(negedge clock);
    recebe_dado = 1'b1;
    @(negedge clock);
    recebe_dado = 1'b0;
    check("ack_clears_tem", 32'(tem_dado), 32'd0);
    check("ack_holds_dado", 32'(dado_recebido), 32'h41);
    recebe_dado = 1'b1;
    @(negedge clock);
    recebe_dado = 1'b0;
    check("ack_idle_ignored", 32'(tem_dado), 32'd0);

    // 0x43 has three ones, so odd parity needs p=0; send p=1 to force a parity error.
    // recebe_dado is held during the store cycle: the set must win.
    fork
      full_frame(7'h43, 1'b1, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clock);
        recebe_dado = 1'b1;
        @(negedge clock);
        recebe_dado = 1'b0;
      end
    join
    check("par_err_flag", 32'(paridade_ok), 32'd0);
    recebe_dado = 1'b1;
    @(negedge clock);
    recebe_dado = 1'b0;

    // 0x55 with the stop bit low: framing error, good parity.
    full_frame(7'h55, odd_par(7'h55), 1'b0);
    repeat (20) @(negedge clock);

    // 100-cycle glitch on the idle line must be rejected at the start-bit midpoint.
    dado_serial = 1'b0;
    repeat (50) @(negedge clock);
    check("glitch_espera", 32'(db_estado), 32'd2);
    repeat (50) @(negedge clock);
    dado_serial = 1'b1;
    repeat (300) @(negedge clock);
    check("glitch_prepara", 32'(db_estado),     32'd1);
    check("glitch_dado",    32'(dado_recebido), 32'h55);
    check("glitch_err",     32'(erro_quadro),   32'd1);
    check("glitch_par",     32'(paridade_ok),   32'd1);
    check("glitch_tem",     32'(tem_dado),      32'd1);

    // Reset pulse in the middle of data bit 3 aborts the frame.
    drive_frame(7'h2A, odd_par(7'h2A), 1'b1, 4 * CLKS + CLKS / 2, 1'b0);
    check("mid_frame_recebe", 32'(db_estado), 32'd3);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_estado", 32'(db_estado),     32'd0);
    check("abort_dado",   32'(dado_recebido), 32'd0);
    check("abort_tem",    32'(tem_dado),      32'd0);
    check("abort_err",    32'(erro_quadro),   32'd0);
    repeat (10) @(negedge clock);
    full_frame(7'h30, odd_par(7'h30), 1'b1);

    // Back-to-back frames without acknowledge: the second overwrites the first.
    full_frame(7'h31, odd_par(7'h31), 1'b1);
    full_frame(7'h32, odd_par(7'h32), 1'b1);
    repeat (10) @(negedge clock);
    check("b2b_dado", 32'(dado_recebido), 32'h32);
    check("b2b_tem",  32'(tem_dado),      32'd1);
    check("b2b_par",  32'(paridade_ok),   32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
